// File: rtl/syslatch_seq_if.sv
// Command/handshake bundle between the 68K decode, the host port and the latch sequencer.
interface syslatch_seq_if;
   logic       CPU_WR;
   logic [3:0] CPU_ADDR;
   logic       HOST_REQ;
   logic [7:0] HOST_DATA;
   logic       HOST_ACK;
   logic [3:0] LATCH_ADDR;
   logic       nBITW1;
   logic       BUSY;
   logic [7:0] LATCH_STATE;

   modport master (
      output CPU_WR, CPU_ADDR, HOST_REQ, HOST_DATA,
      input  HOST_ACK, LATCH_ADDR, nBITW1, BUSY, LATCH_STATE
   );

   modport slave (
      input  CPU_WR, CPU_ADDR, HOST_REQ, HOST_DATA,
      output HOST_ACK, LATCH_ADDR, nBITW1, BUSY, LATCH_STATE
   );
endinterface

// File: rtl/syslatch_seq.sv
// System latch sequencer: arbitrates 68K single-bit writes against boot/host image loads
// and mirrors the latch contents for readback.
module syslatch_seq #(
   parameter logic [7:0] BOOT_IMAGE = 8'h00,
   parameter bit         BOOT_APPLY = 1'b1
) (
   input logic           CLK,
   input logic           RESET,
   input logic           CLK_EN_68K_P,
   syslatch_seq_if.slave bus
);

   typedef enum logic [1:0] {StBoot, StIdle, StHost} state_e;

   localparam state_e ResetState = BOOT_APPLY ? StBoot : StIdle;

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] img_q, img_d;
   logic       armed_q, armed_d;
   logic [3:0] addr_q, addr_d;
   logic       nbitw_q, nbitw_d;
   logic       busy_q, busy_d;
   logic [7:0] mirror_q, mirror_d;
   logic       ack_q, ack_d;

   logic seq_step;
   logic accept;
   logic last_bit;

   // CPU commands always win the tick; the sequence only advances on CPU-free ticks.
   assign seq_step = CLK_EN_68K_P && !bus.CPU_WR && (state_q != StIdle);
   assign accept   = CLK_EN_68K_P && !bus.CPU_WR && (state_q == StIdle) &&
                     bus.HOST_REQ && armed_q;
   assign last_bit = (idx_q == 4'd7);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ResetState;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (seq_step && last_bit) begin
         state_d = StIdle;
      end else if (accept) begin
         state_d = StHost;
      end
   end

   always_comb begin
      idx_d    = idx_q;
      img_d    = img_q;
      armed_d  = armed_q;
      addr_d   = addr_q;
      nbitw_d  = nbitw_q;
      busy_d   = busy_q;
      mirror_d = mirror_q;
      ack_d    = 1'b0;
      if (CLK_EN_68K_P) begin
         busy_d  = (state_q != StIdle);
         nbitw_d = 1'b1;
         if (!bus.HOST_REQ) begin
            armed_d = 1'b1;
         end
         if (bus.CPU_WR) begin
            addr_d  = bus.CPU_ADDR;
            nbitw_d = 1'b0;
         end else if (seq_step) begin
            addr_d  = {img_q[idx_q[2:0]], idx_q[2:0]};
            nbitw_d = 1'b0;
            idx_d   = last_bit ? 4'd0 : idx_q + 4'd1;
            ack_d   = (state_q == StHost) && last_bit;
         end else if (accept) begin
            img_d   = bus.HOST_DATA;
            idx_d   = 4'd0;
            armed_d = 1'b0;
         end
         if (!nbitw_d) begin
            mirror_d[addr_d[2:0]] = addr_d[3];
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx_q    <= 4'd0;
         img_q    <= BOOT_IMAGE;
         armed_q  <= 1'b1;
         addr_q   <= 4'd0;
         nbitw_q  <= 1'b1;
         busy_q   <= BOOT_APPLY;
         mirror_q <= 8'h00;
         ack_q    <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         img_q    <= img_d;
         armed_q  <= armed_d;
         addr_q   <= addr_d;
         nbitw_q  <= nbitw_d;
         busy_q   <= busy_d;
         mirror_q <= mirror_d;
         ack_q    <= ack_d;
      end
   end

   assign bus.LATCH_ADDR  = addr_q;
   assign bus.nBITW1      = nbitw_q;
   assign bus.BUSY        = busy_q;
   assign bus.LATCH_STATE = mirror_q;
   assign bus.HOST_ACK    = ack_q;

endmodule

// File: tb/tb_syslatch_seq.sv
// Directed bench for syslatch_seq: boot, host loads, CPU interleave, reset abort, enable freeze.
module tb_syslatch_seq;

   logic clk;
   logic rst;
   logic en;

   int n_cmp;
   int n_fail;
   int ack_cnt;
   logic ack_a;
   logic ack_b;

   syslatch_seq_if bus ();

   syslatch_seq #(
      .BOOT_IMAGE (8'hA5),
      .BOOT_APPLY (1'b1)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .CLK_EN_68K_P (en),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One enable period: enabled edge, then a disabled edge. HOST_ACK sampled after each.
   task automatic tick();
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      ack_a = bus.HOST_ACK;
      if (ack_a) ack_cnt++;
      @(posedge clk);
      #1;
      ack_b = bus.HOST_ACK;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.nBITW1 !== 1'b1) begin
         $display("FAIL reset_nbitw got %b want 1", bus.nBITW1); n_fail++;
      end
      n_cmp++;
      if (bus.LATCH_ADDR !== 4'h0) begin
         $display("FAIL reset_addr got %h want 0", bus.LATCH_ADDR); n_fail++;
      end
      n_cmp++;
      if (bus.LATCH_STATE !== 8'h00) begin
         $display("FAIL reset_state got %h want 00", bus.LATCH_STATE); n_fail++;
      end
      n_cmp++;
      if (bus.BUSY !== 1'b1 || bus.HOST_ACK !== 1'b0) begin
         $display("FAIL reset_busy_ack got %b%b want 10", bus.BUSY, bus.HOST_ACK); n_fail++;
      end
      rst = 1'b0;
   endtask

   task automatic test_boot();
      logic [7:0] img;
      logic [3:0] exp;
      int ack0;
      img  = 8'hA5;
      ack0 = ack_cnt;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = {img[i], i[2:0]};
         n_cmp++;
         if (bus.LATCH_ADDR !== exp || bus.nBITW1 !== 1'b0 || bus.BUSY !== 1'b1) begin
            $display("FAIL boot_bit%0d got addr=%h n=%b busy=%b want addr=%h n=0 busy=1",
                     i, bus.LATCH_ADDR, bus.nBITW1, bus.BUSY, exp); n_fail++;
         end
      end
      n_cmp++;
      if (bus.LATCH_STATE !== 8'hA5) begin
         $display("FAIL boot_image got %h want a5", bus.LATCH_STATE); n_fail++;
      end
      tick();
      n_cmp++;
      if (bus.nBITW1 !== 1'b1 || bus.BUSY !== 1'b0 || bus.LATCH_ADDR !== 4'hF) begin
         $display("FAIL boot_done got n=%b busy=%b addr=%h want n=1 busy=0 addr=f",
                  bus.nBITW1, bus.BUSY, bus.LATCH_ADDR); n_fail++;
      end
      n_cmp++;
      if (ack_cnt !== ack0) begin
         $display("FAIL boot_no_ack got %0d pulses want 0", ack_cnt - ack0); n_fail++;
      end
   endtask

   task automatic test_host_load();
      logic [7:0] img;
      logic [3:0] exp;
      int ack0;
      img  = 8'h3C;
      ack0 = ack_cnt;
      bus.HOST_DATA = img;
      bus.HOST_REQ  = 1'b1;
      tick();
      n_cmp++;
      if (bus.nBITW1 !== 1'b1 || bus.BUSY !== 1'b0) begin
         $display("FAIL host_accept got n=%b busy=%b want n=1 busy=0", bus.nBITW1, bus.BUSY);
         n_fail++;
      end
      bus.HOST_DATA = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = {img[i], i[2:0]};
         n_cmp++;
         if (bus.LATCH_ADDR !== exp || bus.nBITW1 !== 1'b0 || bus.BUSY !== 1'b1 ||
             ack_a !== (i == 7) || ack_b !== 1'b0) begin
            $display("FAIL host_bit%0d got addr=%h n=%b busy=%b ack=%b%b want addr=%h n=0 busy=1 ack=%b0",
                     i, bus.LATCH_ADDR, bus.nBITW1, bus.BUSY, ack_a, ack_b, exp, (i == 7));
            n_fail++;
         end
      end
      n_cmp++;
      if (bus.LATCH_STATE !== 8'h3C) begin
         $display("FAIL host_image got %h want 3c", bus.LATCH_STATE); n_fail++;
      end
      // Request still held: must not reload.
      repeat (3) tick();
      n_cmp++;
      if (bus.nBITW1 !== 1'b1 || bus.BUSY !== 1'b0 || ack_cnt !== ack0 + 1) begin
         $display("FAIL host_no_reload got n=%b busy=%b acks=%0d want n=1 busy=0 acks=1",
                  bus.nBITW1, bus.BUSY, ack_cnt - ack0); n_fail++;
      end
   endtask

   task automatic test_cpu_inject();
      logic [3:0] exp_seq [9];
      exp_seq = '{4'h8, 4'h9, 4'hA, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      bus.HOST_REQ = 1'b0;
      tick();
      bus.HOST_DATA = 8'hFF;
      bus.HOST_REQ  = 1'b1;
      tick();
      n_cmp++;
      if (bus.nBITW1 !== 1'b1) begin
         $display("FAIL inject_accept got n=%b want 1", bus.nBITW1); n_fail++;
      end
      for (int j = 0; j < 9; j++) begin
         bus.CPU_WR   = (j == 3);
         bus.CPU_ADDR = 4'b0111;
         tick();
         n_cmp++;
         if (bus.LATCH_ADDR !== exp_seq[j] || bus.nBITW1 !== 1'b0 || ack_a !== (j == 8)) begin
            $display("FAIL inject_tick%0d got addr=%h n=%b ack=%b want addr=%h n=0 ack=%b",
                     j, bus.LATCH_ADDR, bus.nBITW1, ack_a, exp_seq[j], (j == 8)); n_fail++;
         end
         if (j == 3) begin
            n_cmp++;
            if (bus.LATCH_STATE !== 8'h3F) begin
               $display("FAIL inject_mirror got %h want 3f", bus.LATCH_STATE); n_fail++;
            end
         end
      end
      bus.CPU_WR = 1'b0;
      n_cmp++;
      if (bus.LATCH_STATE !== 8'hFF) begin
         $display("FAIL inject_image got %h want ff", bus.LATCH_STATE); n_fail++;
      end
   endtask

   task automatic test_same_tick_and_reset();
      int ack0;
      bus.HOST_REQ = 1'b0;
      tick();
      ack0 = ack_cnt;
      bus.CPU_WR    = 1'b1;
      bus.CPU_ADDR  = 4'b0011;
      bus.HOST_REQ  = 1'b1;
      bus.HOST_DATA = 8'h0F;
      tick();
      n_cmp++;
      if (bus.LATCH_ADDR !== 4'h3 || bus.nBITW1 !== 1'b0 || bus.LATCH_STATE !== 8'hF7) begin
         $display("FAIL same_cpu got addr=%h n=%b st=%h want addr=3 n=0 st=f7",
                  bus.LATCH_ADDR, bus.nBITW1, bus.LATCH_STATE); n_fail++;
      end
      bus.CPU_WR = 1'b0;
      tick();
      n_cmp++;
      if (bus.nBITW1 !== 1'b1 || bus.BUSY !== 1'b0) begin
         $display("FAIL same_accept got n=%b busy=%b want n=1 busy=0", bus.nBITW1, bus.BUSY);
         n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (bus.LATCH_ADDR !== (4'h8 + 4'(i)) || bus.nBITW1 !== 1'b0 || bus.BUSY !== 1'b1) begin
            $display("FAIL abort_bit%0d got addr=%h n=%b busy=%b want addr=%h n=0 busy=1",
                     i, bus.LATCH_ADDR, bus.nBITW1, bus.BUSY, 4'h8 + 4'(i)); n_fail++;
         end
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.nBITW1 !== 1'b1 || bus.LATCH_STATE !== 8'h00 || bus.LATCH_ADDR !== 4'h0 ||
          bus.BUSY !== 1'b1) begin
         $display("FAIL abort_reset got n=%b st=%h addr=%h busy=%b want n=1 st=00 addr=0 busy=1",
                  bus.nBITW1, bus.LATCH_STATE, bus.LATCH_ADDR, bus.BUSY); n_fail++;
      end
      tick();
      bus.HOST_REQ = 1'b0;
      rst = 1'b0;
      n_cmp++;
      if (ack_cnt !== ack0 || bus.HOST_ACK !== 1'b0) begin
         $display("FAIL abort_no_ack got %0d pulses want 0", ack_cnt - ack0); n_fail++;
      end
   endtask

   task automatic test_boot_freeze();
      logic [7:0] img;
      logic [3:0] exp;
      img = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            repeat (10) @(posedge clk);
            #1;
            n_cmp++;
            if (bus.LATCH_ADDR !== 4'hA || bus.nBITW1 !== 1'b0 || bus.BUSY !== 1'b1 ||
                bus.LATCH_STATE !== 8'h05) begin
               $display("FAIL freeze_hold got addr=%h n=%b busy=%b st=%h want addr=a n=0 busy=1 st=05",
                        bus.LATCH_ADDR, bus.nBITW1, bus.BUSY, bus.LATCH_STATE); n_fail++;
            end
         end
         tick();
         exp = {img[i], i[2:0]};
         n_cmp++;
         if (bus.LATCH_ADDR !== exp || bus.nBITW1 !== 1'b0) begin
            $display("FAIL reboot_bit%0d got addr=%h n=%b want addr=%h n=0",
                     i, bus.LATCH_ADDR, bus.nBITW1, exp); n_fail++;
         end
      end
      tick();
      n_cmp++;
      if (bus.LATCH_STATE !== 8'hA5 || bus.BUSY !== 1'b0 || bus.nBITW1 !== 1'b1) begin
         $display("FAIL reboot_done got st=%h busy=%b n=%b want st=a5 busy=0 n=1",
                  bus.LATCH_STATE, bus.BUSY, bus.nBITW1); n_fail++;
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      ack_cnt       = 0;
      ack_a         = 1'b0;
      ack_b         = 1'b0;
      rst           = 1'b1;
      en            = 1'b0;
      bus.CPU_WR    = 1'b0;
      bus.CPU_ADDR  = 4'h0;
      bus.HOST_REQ  = 1'b0;
      bus.HOST_DATA = 8'h00;
      test_reset();
      test_boot();
      test_host_load();
      test_cpu_inject();
      test_same_tick_and_reset();
      test_boot_freeze();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
